// File: rtl/sobel_mul_sched.sv
// sobel_mul_sched: round-robin scheduler that time-shares one combinational
// 22x8 unsigned product unit between NREQ requesters. There are two registered
// stages: issue (operands into the multiplier) and result (captured product
// plus requester ID). Both stages stall together under result backpressure.
module sobel_mul_sched #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*22-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [21:0]       mul_din0,
    output logic [7:0]        mul_din1,
    input  logic [28:0]       mul_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [28:0]       res_p,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    logic [IDW-1:0] ptr;
    logic           iss_valid;
    logic [21:0]    iss_a;
    logic [7:0]     iss_b;
    logic [IDW-1:0] iss_id;

    logic           out_en;
    logic           iss_en;
    logic           found;
    logic [IDW-1:0] sel;
    logic           accept;
    logic [IDW-1:0] ptr_next;

    assign out_en   = !res_valid || res_ready;
    assign iss_en   = !iss_valid || out_en;
    assign mul_din0 = iss_a;
    assign mul_din1 = iss_b;
    assign busy     = iss_valid || res_valid;

    // Round-robin search: first valid requester starting at ptr, wrapping mod NREQ.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                sel   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Grant is offered only when the issue stage can take it and not in reset.
    always_comb begin
        req_ready = '0;
        if (found && iss_en && !ap_rst) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << sel;
        end
    end

    assign accept   = |req_ready;
    assign ptr_next = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;

    // Pipeline registers and arbitration pointer; result and issue stages
    // advance on out_en / iss_en and otherwise hold.
    always_ff @(posedge ap_clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (ap_rst) begin
            ptr       <= '0;
            iss_valid <= 1'b0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_id    <= '0;
            res_valid <= 1'b0;
            res_p     <= '0;
            res_id    <= '0;
        end else begin
            if (out_en) begin
                res_valid <= iss_valid;
                if (iss_valid) begin
                    res_p  <= mul_dout;
                    res_id <= iss_id;
                end
            end
            if (iss_en) begin
                if (accept) begin
                    iss_valid <= 1'b1;
                    iss_a     <= req_a[22*sel +: 22];
                    iss_b     <= req_b[8*sel +: 8];
                    iss_id    <= sel;
                    ptr       <= ptr_next;
                end else begin
                    iss_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_mul_sched.sv
// tb_sobel_mul_sched: self-checking bench for sobel_mul_sched. A transaction
// model (round-robin pointer, FIFO of in-flight products, occupancy count)
// predicts grants, busy and every presented result.
module tb_sobel_mul_sched;

    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam longint MASK29 = 64'h1FFF_FFFF;

    logic                ap_clk = 1'b0;
    logic                ap_rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*22-1:0]  req_a = '0;
    logic [NREQ*8-1:0]   req_b = '0;
    logic [21:0]         mul_din0;
    logic [7:0]          mul_din1;
    logic [28:0]         mul_dout;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [28:0]         res_p;
    logic [IDW-1:0]      res_id;
    logic                busy;

    // Combinational product unit: 30-bit full product truncated to 29 bits.
    logic [29:0] full_prod;
    assign full_prod = {8'd0, mul_din0} * {22'd0, mul_din1};
    assign mul_dout  = full_prod[28:0];

    sobel_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int     id;
        longint p;
    } ent_t;

    ent_t        q[$];
    int          acc_log[$];
    int          out_log[$];
    int          ptr_m = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [28:0] prev_p = '0;
    logic [IDW-1:0] prev_id = '0;

    function automatic longint prod_of(int i);
        logic [21:0] a;
        logic [7:0]  b;
        a = req_a[22*i +: 22];
        b = req_b[8*i +: 8];
        return (longint'(a) * longint'(b)) & MASK29;
    endfunction

    task automatic set_op(input int i, input logic [21:0] a, input logic [7:0] b);
        req_a[22*i +: 22] = a;
        req_b[8*i +: 8]   = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 22'($urandom), 8'($urandom));
        end
    endtask

    // One clock: checks at the falling edge, model update just after the rising edge.
    task automatic cycle();
        logic [NREQ-1:0] g;
        int     gi;
        longint gp;
        logic   do_pop, rst_now, stall_now;
        @(negedge ap_clk);
        cyc++;
        gi = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (gi < 0 && req_valid[(ptr_m + k) % NREQ]) gi = (ptr_m + k) % NREQ;
        end
        g = '0;
        if (gi >= 0 && !ap_rst && (q.size() < 2 || res_ready)) g[gi] = 1'b1;
        total++;
        if (req_ready !== g) begin
            bad++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, g);
        end
        total++;
        if (busy !== (q.size() > 0)) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() > 0);
        end
        if (res_valid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL res_unexpected cyc=%0d got id=%0d p=%h exp none", cyc, res_id, res_p);
            end else if (res_p !== q[0].p[28:0] || res_id !== IDW'(q[0].id)) begin
                bad++;
                $display("FAIL result cyc=%0d got id=%0d p=%h exp id=%0d p=%h",
                         cyc, res_id, res_p, q[0].id, q[0].p[28:0]);
            end
        end
        if (prev_stall) begin
            total++;
            if (res_valid !== 1'b1 || res_p !== prev_p || res_id !== prev_id) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got v=%b id=%0d p=%h exp v=1 id=%0d p=%h",
                         cyc, res_valid, res_id, res_p, prev_id, prev_p);
            end
        end
        do_pop    = (res_valid === 1'b1) && res_ready;
        stall_now = (res_valid === 1'b1) && !res_ready;
        rst_now   = ap_rst;
        prev_p    = res_p;
        prev_id   = res_id;
        gp        = (g != '0) ? prod_of(gi) : 0;
        @(posedge ap_clk);
        #1;
        if (rst_now) begin
            q.delete();
            ptr_m      = 0;
            prev_stall = 1'b0;
        end else begin
            if (do_pop && q.size() > 0) begin
                out_log.push_back(q[0].id);
                void'(q.pop_front());
            end
            if (g != '0) begin
                q.push_back('{id: gi, p: gp});
                acc_log.push_back(gi);
                ptr_m = (gi + 1) % NREQ;
            end
            prev_stall = stall_now;
        end
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        res_ready = 1'b1;
        n = 0;
        while ((q.size() > 0 || busy !== 1'b0) && n < 20) begin
            cycle();
            n++;
        end
        total++;
        if (q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain got pending=%0d busy=%b exp pending=0 busy=0", q.size(), busy);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        req_valid = '1;
        rand_ops();
        cycle();
        cycle();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || mul_din0 !== 22'd0 || mul_din1 !== 8'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b busy=%b din0=%h din1=%h exp 0 0 0 0",
                     res_valid, busy, mul_din0, mul_din1);
        end
        req_valid = '0;
        ap_rst = 1'b0;
        cycle();
    endtask

    task automatic test_single_op();
        res_ready = 1'b1;
        set_op(1, 22'd1000, 8'd3);
        req_valid = 3'b010;
        cycle();
        req_valid = '0;
        total++;
        if (acc_log.size() == 0 || acc_log[$] != 1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_accept got v=%b exp accept id 1 and v=0", res_valid);
        end
        cycle();
        total++;
        if (res_valid !== 1'b1 || res_p !== 29'd3000 || res_id !== 2'd1) begin
            bad++;
            $display("FAIL single_result got v=%b id=%0d p=%0d exp v=1 id=1 p=3000",
                     res_valid, res_id, res_p);
        end
        cycle();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_once got v=%b exp v=0", res_valid);
        end
    endtask

    task automatic test_max_operands();
        longint exp_max;
        exp_max = (longint'(22'h3FFFFF) * 255) & MASK29;
        res_ready = 1'b1;
        set_op(0, 22'h3FFFFF, 8'hFF);
        req_valid = 3'b001;
        cycle();
        req_valid = '0;
        cycle();
        total++;
        if (res_valid !== 1'b1 || res_p !== exp_max[28:0]) begin
            bad++;
            $display("FAIL max_operands got v=%b p=%h exp v=1 p=%h", res_valid, res_p, exp_max[28:0]);
        end
        set_op(2, 22'd0, 8'd255);
        req_valid = 3'b100;
        cycle();
        req_valid = '0;
        cycle();
        total++;
        if (res_valid !== 1'b1 || res_p !== 29'd0 || res_id !== 2'd2) begin
            bad++;
            $display("FAIL zero_operand got v=%b id=%0d p=%h exp v=1 id=2 p=0", res_valid, res_id, res_p);
        end
        drain();
    endtask

    task automatic test_fairness();
        int a0, o0;
        res_ready = 1'b1;
        a0 = acc_log.size();
        o0 = out_log.size();
        req_valid = '1;
        for (int c = 0; c < 9; c++) begin
            rand_ops();
            cycle();
        end
        drain();
        for (int j = 0; j < 9; j++) begin
            total++;
            if (acc_log.size() <= a0 + j || acc_log[a0 + j] != j % NREQ) begin
                bad++;
                $display("FAIL fair_grant idx=%0d got=%0d exp=%0d", j,
                         (acc_log.size() > a0 + j) ? acc_log[a0 + j] : -1, j % NREQ);
            end
        end
        total++;
        if (out_log.size() != o0 + 9 || out_log[o0 + 8] != 2) begin
            bad++;
            $display("FAIL fair_results got count=%0d exp count=%0d", out_log.size() - o0, 9);
        end
    endtask

    task automatic test_back_to_back();
        int a0, o0;
        a0 = acc_log.size();
        o0 = out_log.size();
        res_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 4; c++) begin
            rand_ops();
            cycle();
        end
        res_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rand_ops();
            cycle();
        end
        total++;
        if (req_ready !== '0 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_stall got ready=%b v=%b exp ready=000 v=1", req_ready, res_valid);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_ops();
            cycle();
        end
        drain();
        total++;
        if (out_log.size() - o0 != acc_log.size() - a0) begin
            bad++;
            $display("FAIL bp_count got out=%0d exp=%0d", out_log.size() - o0, acc_log.size() - a0);
        end
    endtask

    task automatic test_rotation_skip();
        int a0;
        res_ready = 1'b1;
        req_valid = 3'b001;
        rand_ops();
        cycle();
        a0 = acc_log.size();
        req_valid = 3'b101;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            cycle();
        end
        total++;
        if (acc_log.size() != a0 + 3 || acc_log[a0] != 2 || acc_log[a0 + 1] != 0 || acc_log[a0 + 2] != 2) begin
            bad++;
            $display("FAIL rotation_skip got n=%0d exp grants 2,0,2", acc_log.size() - a0);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int a0;
        res_ready = 1'b0;
        req_valid = 3'b110;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            cycle();
        end
        total++;
        if (q.size() != 2 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL pipe_full got pending=%0d v=%b exp pending=2 v=1", q.size(), res_valid);
        end
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
        req_valid = '0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || mul_din0 !== 22'd0) begin
            bad++;
            $display("FAIL midflight_reset got v=%b busy=%b din0=%h exp 0 0 0", res_valid, busy, mul_din0);
        end
        a0 = acc_log.size();
        res_ready = 1'b1;
        req_valid = '1;
        rand_ops();
        cycle();
        total++;
        if (acc_log.size() != a0 + 1 || acc_log[a0] != 0) begin
            bad++;
            $display("FAIL post_reset_grant got n=%0d exp first grant 0", acc_log.size() - a0);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_max_operands();
        test_fairness();
        test_back_to_back();
        test_rotation_skip();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
